// File: rtl/conv_controller.sv
// -----------------------------------------------------------------------------
// conv_controller
//
// Sequences one convolution pass. The kernel weights are loaded first, then an
// image is streamed in raster order into a combinational convolution datapath.
// This block sits outside that datapath. It produces the shift strobes, tracks
// the pixel position, and flags when the datapath's adder output holds a
// complete KERNEL_SIZE x KERNEL_SIZE window result.
//
// Parameters
//   KERNEL_SIZE : kernel edge length (weight count is KERNEL_SIZE**2)
//   IMG_WIDTH   : pixels per image row
//   IMG_HEIGHT  : rows per image
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : pulse that begins one weight-load plus image pass (IDLE only)
//   w_valid      : upstream offers one weight word this cycle
//   weight_write : datapath weight-shift strobe (w_valid while loading)
//   weight_idx   : index of the weight being written, 0..KERNEL_SIZE**2-1
//   pix_valid    : upstream offers one pixel this cycle
//   pix_ready    : controller accepts a pixel this cycle
//   write        : datapath pixel-window shift strobe (pix_valid & pix_ready)
//   out_valid    : datapath add_result holds a valid convolution result
//   out_ready    : downstream consumes the result when high with out_valid
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse at the end of a pass
// -----------------------------------------------------------------------------
module conv_controller #(
  parameter  int KERNEL_SIZE = 5,
  parameter  int IMG_WIDTH   = 28,
  parameter  int IMG_HEIGHT  = 28,
  localparam int NUM_W       = KERNEL_SIZE * KERNEL_SIZE,
  localparam int IDX_W       = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             w_valid,
  output logic             weight_write,
  output logic [IDX_W-1:0] weight_idx,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [IDX_W-1:0] LAST_W   = IDX_W'(NUM_W - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  // First column/row at which the window is completely filled with image data.
  localparam logic [COL_W-1:0] FULL_COL = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] FULL_ROW = ROW_W'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] widx_reg, widx_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic             out_valid_reg, out_valid_next;
  logic             result_write;  // this write completes a full window

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      widx_reg      <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      widx_reg      <= widx_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    widx_next      = widx_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    out_valid_next = out_valid_reg;
    result_write   = 1'b0;
    weight_write   = 1'b0;
    pix_ready      = 1'b0;
    write          = 1'b0;
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD_W;
          widx_next  = '0;
        end
      end

      LOAD_W: begin
        weight_write = w_valid;
        if (w_valid) begin
          if (widx_reg == LAST_W) begin
            widx_next  = '0;
            col_next   = '0;
            row_next   = '0;
            state_next = RUN;
          end else begin
            widx_next = widx_reg + 1'b1;
          end
        end
      end

      RUN: begin
        // An unconsumed result would be overwritten by the next window shift,
        // so input is stalled until downstream takes it.
        pix_ready = !(out_valid_reg && !out_ready);
        write     = pix_valid && pix_ready;
        if (write) begin
          result_write = (row_reg >= FULL_ROW) && (col_reg >= FULL_COL);
          if (col_reg == LAST_COL) begin
            col_next = '0;
            if (row_reg == LAST_ROW) begin
              row_next   = '0;
              state_next = DRAIN;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end

      DRAIN: begin
        // Wait for the last result (if any) to leave before ending the pass.
        if (!out_valid_reg || out_ready) begin
          state_next = DONE;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A fresh result in the same cycle as a consume keeps out_valid high.
    if (result_write) begin
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  assign weight_idx = widx_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_conv_controller.sv
// -----------------------------------------------------------------------------
// tb_conv_controller
//
// Bench for conv_controller with KERNEL_SIZE=5 on a 6x6 image. Weight loads
// are checked from a vector table. Pixel passes use a scoreboard: the index of
// every window-completing write is queued. When a result is consumed, the
// queue head must equal the most recent write.
// -----------------------------------------------------------------------------
module tb_conv_controller;

  localparam int K  = 5;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int NW = K * K;
  localparam int IW = $clog2(NW);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          w_valid;
  logic          weight_write;
  logic [IW-1:0] weight_idx;
  logic          pix_valid;
  logic          pix_ready;
  logic          write;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  conv_controller #(
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_valid     (w_valid),
    .weight_write(weight_write),
    .weight_idx  (weight_idx),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .write       (write),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Weight-load vector table: inputs for one cycle plus the expected outputs.
  typedef struct {
    logic          start;
    logic          w_valid;
    logic          pix_valid;
    logic          ex_ww;
    logic [IW-1:0] ex_idx;
    logic          ex_busy;
    logic          ex_pready;
    logic          ex_done;
  } vec_t;

  vec_t tbl[$];

  // One IDLE cycle with start, then the weight stream (w_valid every gap-th
  // cycle, with a stray start and pixels offered throughout), then the first
  // RUN cycle with nothing offered.
  task automatic build_load(input int gap);
    vec_t v;
    int   nwr;
    tbl.delete();
    v = '{start: 1'b1, w_valid: 1'b0, pix_valid: 1'b0, ex_ww: 1'b0,
          ex_idx: '0, ex_busy: 1'b0, ex_pready: 1'b0, ex_done: 1'b0};
    tbl.push_back(v);
    nwr = 0;
    for (int i = 0; nwr < NW; i++) begin
      v.start     = (i == 1);
      v.w_valid   = ((i % gap) == 0);
      v.pix_valid = 1'b1;
      v.ex_ww     = v.w_valid;
      v.ex_idx    = nwr[IW-1:0];
      v.ex_busy   = 1'b1;
      v.ex_pready = 1'b0;
      v.ex_done   = 1'b0;
      tbl.push_back(v);
      if (v.w_valid) nwr++;
    end
    v = '{start: 1'b0, w_valid: 1'b0, pix_valid: 1'b0, ex_ww: 1'b0,
          ex_idx: '0, ex_busy: 1'b1, ex_pready: 1'b1, ex_done: 1'b0};
    tbl.push_back(v);
  endtask

  task automatic apply_load(input string tag);
    logic [8:0] act, exp;
    for (int i = 0; i < tbl.size(); i++) begin
      start     = tbl[i].start;
      w_valid   = tbl[i].w_valid;
      pix_valid = tbl[i].pix_valid;
      out_ready = 1'b1;
      @(negedge clk);
      act = {weight_write, weight_idx, busy, pix_ready, done};
      exp = {tbl[i].ex_ww, tbl[i].ex_idx, tbl[i].ex_busy, tbl[i].ex_pready, tbl[i].ex_done};
      $display("[TB] %s vec %0d: ww=%0b idx=%0d busy=%0b prdy=%0b", tag, i,
               weight_write, weight_idx, busy, pix_ready);
      check({tag, "_vec"}, 32'(act), 32'(exp));
      @(posedge clk);
      #1;
    end
  endtask

  // Stream one image. stall: hold out_ready low for 3 cycles per result.
  // abort_at >= 0: assert reset asynchronously before pixel abort_at.
  task automatic stream_pass(input string tag, input bit stall, input int abort_at);
    int  q[$];
    int  sent, last_wr, results, done_cnt, stall_cnt, exp_idx;
    bit  finished;
    sent = 0; last_wr = -1; results = 0; done_cnt = 0; stall_cnt = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      pix_valid = (sent < W * H);
      out_ready = stall ? (stall_cnt >= 3) : 1'b1;
      start     = (cyc == 7);
      w_valid   = ((cyc % 2) == 0);
      if (abort_at >= 0 && sent == abort_at) begin
        pix_valid = 1'b1;
        w_valid   = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        $display("[TB] %s reset at pixel %0d", tag, sent);
        check({tag, "_async_reset"},
              32'({weight_write, weight_idx, write, pix_ready, out_valid, busy, done}), 32'd0);
        finished = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end else begin
        @(negedge clk);
        check({tag, "_no_ww_in_run"}, 32'(weight_write), 32'd0);
        if (out_valid && !out_ready)
          check({tag, "_stall_blocks"}, 32'({pix_ready, write}), 32'd0);
        else if (sent < W * H)
          check({tag, "_pix_ready"}, 32'(pix_ready), 32'd1);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check({tag, "_spurious_result"}, 32'(last_wr), 32'hFFFF_FFFF);
          end else begin
            exp_idx = q.pop_front();
            $display("[TB] %s result %0d after pixel %0d", tag, results, last_wr);
            check({tag, "_result_pos"}, 32'(last_wr), 32'(exp_idx));
          end
          results++;
          stall_cnt = 0;
        end else if (out_valid) begin
          stall_cnt++;
        end
        if (write) begin
          check({tag, "_write_needs_valid"}, 32'(pix_valid), 32'd1);
          if ((sent / W) >= K - 1 && (sent % W) >= K - 1) q.push_back(sent);
          last_wr = sent;
          sent++;
        end
        if (done) begin
          done_cnt++;
          finished = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0; pix_valid = 1'b0; w_valid = 1'b0;
          @(negedge clk);
          check({tag, "_done_one_cycle_idle"}, 32'({done, busy}), 32'd0);
        end
        @(posedge clk);
        #1;
      end
    end
    if (abort_at < 0) begin
      check({tag, "_pixels_written"}, 32'(sent), 32'(W * H));
      check({tag, "_result_count"}, 32'(results), 32'((W - K + 1) * (H - K + 1)));
      check({tag, "_results_pending"}, 32'(q.size()), 32'd0);
      check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; w_valid = 1'b1; pix_valid = 1'b1; out_ready = 1'b1;
    #12;
    check("reset_outputs",
          32'({weight_write, weight_idx, write, pix_ready, out_valid, busy, done}), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ignores_inputs", 32'({weight_write, pix_ready, write, busy}), 32'd0);
    @(posedge clk);
    #1;

    build_load(1);
    apply_load("load_contig");
    stream_pass("pass_stream", 1'b0, -1);

    build_load(3);
    apply_load("load_gapped");
    stream_pass("pass_stall", 1'b1, -1);

    build_load(1);
    apply_load("load_pre_abort");
    stream_pass("pass_abort", 1'b0, 20);
    start = 1'b0; pix_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    check("idle_after_abort", 32'({weight_write, pix_ready, write, busy, out_valid}), 32'd0);
    @(posedge clk);
    #1;
    build_load(1);
    apply_load("load_reload");
    stream_pass("pass_reload", 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_controller.md
CONV_CONTROLLER -- requirements
Module: conv_controller

Interface
REQ-001: Parameter KERNEL_SIZE, default 5, kernel edge length; weight count is KERNEL_SIZE**2.
REQ-002: Parameter IMG_WIDTH, default 28, pixels per image row.
REQ-003: Parameter IMG_HEIGHT, default 28, rows per image.
REQ-004: Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005: Port reset, input, 1, asynchronous active-high reset.
REQ-006: Port start, input, 1, pulse that begins one weight-load plus image pass.
REQ-007: Port w_valid, input, 1, upstream offers one weight word this cycle.
REQ-008: Port weight_write, output, 1, datapath weight-shift strobe.
REQ-009: Port weight_idx, output, clog2(KERNEL_SIZE**2), index of the weight being written.
REQ-010: Port pix_valid, input, 1, upstream offers one pixel this cycle.
REQ-011: Port pix_ready, output, 1, controller accepts a pixel this cycle.
REQ-012: Port write, output, 1, datapath pixel-window shift strobe; equals pix_valid AND pix_ready.
REQ-013: Port out_valid, output, 1, datapath add_result holds a valid convolution result.
REQ-014: Port out_ready, input, 1, downstream consumes the result when high with out_valid.
REQ-015: Port busy, output, 1, high in every state except IDLE.
REQ-016: Port done, output, 1, one-cycle pulse at end of pass.

Function
REQ-017: FSM states SHALL be IDLE, LOAD_W, RUN, DRAIN, DONE.
REQ-018: IDLE -> LOAD_W on start; start in any other state SHALL be ignored.
REQ-019: LOAD_W: weight_write = w_valid; weight_idx increments per write starting at 0; after write at index KERNEL_SIZE**2-1 -> RUN, weight_idx returns to 0.
REQ-020: w_valid outside LOAD_W SHALL be ignored (weight_write low).
REQ-021: pix_ready SHALL be high only in RUN and only when NOT (out_valid AND NOT out_ready).
REQ-022: Column counter 0..IMG_WIDTH-1 SHALL advance per write, wrap to 0 and increment row counter 0..IMG_HEIGHT-1.
REQ-023: A write at (row, col) with row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1 SHALL set out_valid on the next cycle (datapath is combinational; latency 1 cycle from write).
REQ-024: out_valid SHALL hold until the cycle out_ready is high, then clear unless a new qualifying write occurs that same cycle, in which case it stays high.
REQ-025: Writes at (row, col) with row < KERNEL_SIZE-1 or col < KERNEL_SIZE-1 SHALL NOT set out_valid.
REQ-026: Results per pass SHALL total (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1).
REQ-027: Write at (IMG_HEIGHT-1, IMG_WIDTH-1) -> DRAIN; counters return to 0.
REQ-028: DRAIN -> DONE once out_valid is low or is consumed (out_ready high) that cycle.
REQ-029: DONE asserts done for exactly one cycle, then -> IDLE.
REQ-030: pix_valid outside RUN SHALL be ignored; no counter changes.

Reset
REQ-031: reset high SHALL asynchronously force state IDLE, counters and weight_idx 0, and weight_write, write, pix_ready, out_valid, busy, done low.
REQ-032: reset mid-pass SHALL abandon the pass; a new start is required, including full weight reload.

Verification
REQ-033: KERNEL_SIZE=5, IMG 6x6; start, 25 w_valid cycles -> 25 weight_write pulses, idx 0..24, state RUN next cycle.
REQ-034: Same config, 36 pixels streamed with out_ready=1 -> exactly 4 out_valid cycles, one cycle after writes at (4,4),(4,5),(5,4),(5,5); done pulse follows; busy low after.
REQ-035: out_ready held 0 after first result -> pix_ready low, no writes, out_valid held; out_ready=1 for one cycle -> streaming resumes, no result lost or duplicated.
REQ-036: w_valid gapped (1 of every 3 cycles) -> weight_idx advances only on w_valid; RUN entered only after 25th write.
REQ-037: reset asserted at pixel 20 -> all outputs 0 immediately (asynchronously); later start plus reload yields a correct 4-result pass.
REQ-038: start pulsed during RUN and pix_valid during LOAD_W -> no effect on state, counters or outputs.
